ysyx_25050147_ifu: RTL and testbench

//  Instruction fetch stage: owns the architectural PC and issues one 32-bit instruction read per fetch.

---
 rtl/ysyx_25050147_pkg.sv | 24 ++
 rtl/ysyx_25050147.sv | 1 +
 rtl/ysyx_25050147_ifu_pc.sv | 51 +++++
 rtl/ysyx_25050147_ifu.sv | 157 +++++++++++++++
 tb/tb_ysyx_25050147_ifu.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25050147_pkg.sv
// Shared types and constants for the ysyx_25050147 instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_25050147_pkg;

    // Fetch FSM: issue request, wait for response, hold word for the decoder.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } ifu_state_t;

    // Default architectural PC after reset (first fetch address).
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // addi x0, x0, 0 -- harmless filler word.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25050147.sv


// File: rtl/ysyx_25050147_ifu_pc.sv
// PC register with +4 incrementer, aligned redirect mux and the kill flag that
// marks the in-flight fetch as belonging to an abandoned path.
// Latency: pc/kill update on the clock edge after the control pulse; no backpressure.
// Ports: clk, rst (async active-high); i_redirect_vld/i_redirect_pc load a new
//   target; i_advance steps pc by 4; i_kill_set/i_kill_clr drive the kill flag;
//   o_pc is the current fetch PC, o_kill the kill flag.
module ysyx_25050147_ifu_pc
    import ysyx_25050147_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect_vld,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_advance,
    input  logic        i_kill_set,
    input  logic        i_kill_clr,
    output logic [31:0] o_pc,
    output logic        o_kill
);

    logic [31:0] r_pc;
    logic        r_kill;
    logic [31:0] w_pc_nxt;

    // Redirect always wins over sequential advance; wraps mod 2^32.
    assign w_pc_nxt = i_redirect_vld ? align_pc(i_redirect_pc) : (r_pc + 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect_vld || i_advance) begin
            r_pc <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill <= 1'b0;
        end else if (i_kill_set) begin
            r_kill <= 1'b1;
        end else if (i_kill_clr) begin
            r_kill <= 1'b0;
        end
    end

    assign o_pc   = r_pc;
    assign o_kill = r_kill;

endmodule

// File: rtl/ysyx_25050147_ifu.sv
// Instruction fetch stage: owns the PC, one outstanding imem read, buffers {inst, inst_pc} for decode.
// Latency: request accepted in N, response in N+1, inst_valid in N+2 (min 3 cycles/instruction).
// Backpressure: holds inst/inst_pc while inst_ready is low and issues no new request until consumed.
// Ports: clk, rst (async active-high); imem_req_* request channel; imem_rsp_* response
//   pulse; inst_valid/inst_ready/inst/inst_pc to decoder; redirect_valid/redirect_pc
//   single-cycle redirect. With IFU_PERF_EN defined, perf_fetch_cnt/perf_stall_cnt
//   (saturating) are also present.
module ysyx_25050147_ifu
    import ysyx_25050147_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    ifu_state_t  r_state;
    ifu_state_t  w_state_nxt;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic [31:0] w_pc;
    logic        w_kill;
    logic        w_req_hs;
    logic        w_advance;
    logic        w_kill_set;
    logic        w_kill_clr;
    logic        w_load;

    ysyx_25050147_ifu_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .i_redirect_vld(redirect_valid),
        .i_redirect_pc (redirect_pc),
        .i_advance     (w_advance),
        .i_kill_set    (w_kill_set),
        .i_kill_clr    (w_kill_clr),
        .o_pc          (w_pc),
        .o_kill        (w_kill)
    );

    // Request is masked while rst is high even though state already reads REQ.
    assign imem_req_valid = (r_state == REQ) && !rst;
    assign imem_req_addr  = w_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_kill_set  = 1'b0;
        w_kill_clr  = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            REQ: begin
                // A redirect racing an accepted request must still wait out
                // the response of the old address, hence kill + WAIT.
                if (w_req_hs) begin
                    w_state_nxt = WAIT;
                    w_kill_set  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        // Old-path response lands in the redirect cycle: drop it
                        // and go fetch the new target right away.
                        w_state_nxt = REQ;
                        w_kill_clr  = 1'b1;
                    end else begin
                        w_kill_set  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (w_kill) begin
                        w_state_nxt = REQ;
                        w_kill_clr  = 1'b1;
                    end else begin
                        w_state_nxt = OUT;
                        w_load      = 1'b1;
                        w_advance   = 1'b1;
                    end
                end
            end
            OUT: begin
                if (redirect_valid || inst_ready) begin
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = REQ;
            end
        endcase
    end

    // inst_pc takes the pre-increment pc; pc steps to +4 on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else if (w_load) begin
            r_inst    <= imem_rsp_data;
            r_inst_pc <= w_pc;
        end
    end

    assign inst_valid = (r_state == OUT);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

`ifdef IFU_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (inst_valid && inst_ready && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if ((r_state != OUT) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
module tb_ysyx_25050147_ifu;
    import ysyx_25050147_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_25050147_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Stimulus knobs
    int          rdy_mode   = 0;   // 0 always ready, 1 ready after 2 waiting cycles, 2 random
    int          ir_mode    = 0;   // 0 always ready, 1 held low, 2 random
    int          rsp_dly    = 1;
    bit          rand_rsp   = 1'b0;
    int          redir_prob = 0;   // percent per cycle
    bit          redir_now  = 1'b0;
    logic [31:0] redir_tgt  = '0;
    bit          rst_now    = 1'b0;

    // Memory model and reference model state
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          req_age = 0;
    logic [31:0] exp_pc = RESET_PC_DEFAULT;
    int          cyc = 0;
    int          deliv_total = 0;
    int          last_deliv_cyc = 0;
    logic [31:0] last_deliv_pc = '0;
    int          fetch_model = 0;
    int          stall_model = 0;
    bit          prev_req_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered just after a falling edge.
    task automatic tick();
        rst = rst_now;
        case (rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = (req_age >= 2);
            default: imem_req_ready = 1'($urandom_range(0, 1));
        endcase
        if (pend_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = INST_NOP;
        end
        case (ir_mode)
            0:       inst_ready = 1'b1;
            1:       inst_ready = 1'b0;
            default: inst_ready = 1'($urandom_range(0, 1));
        endcase
        if (redir_prob > 0 && $urandom_range(0, 99) < redir_prob) begin
            redir_now = 1'b1;
            redir_tgt = $urandom;
        end
        redirect_valid = redir_now;
        redirect_pc    = redir_tgt;
        redir_now      = 1'b0;
        #1;
        if (rst) begin
            chk("rst_inst_valid", 32'(inst_valid), 0);
            chk("rst_req_valid", 32'(imem_req_valid), 0);
            chk("rst_inst", inst, 0);
            chk("rst_inst_pc", inst_pc, 0);
`ifdef IFU_PERF_EN
            chk("rst_perf_fetch", perf_fetch_cnt, 0);
            chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
            exp_pc         = RESET_PC_DEFAULT;
            fetch_model    = 0;
            stall_model    = 0;
            prev_req_stall = 1'b0;
        end else begin
            if (inst_valid) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst", inst, mem_word(exp_pc));
                chk("no_req_in_out", 32'(imem_req_valid), 0);
            end
            if (imem_req_valid) begin
                chk("req_align", 32'(imem_req_addr[1:0]), 0);
                if (prev_req_stall) chk("req_addr_stable", imem_req_addr, prev_addr);
            end
            if (!inst_valid) stall_model++;
            if (inst_valid && inst_ready) begin
                last_deliv_pc  = inst_pc;
                last_deliv_cyc = cyc;
                deliv_total++;
                fetch_model++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr      = imem_req_addr;
        end
        if (pend_cnt > 0) pend_cnt--;
        if (imem_req_valid && imem_req_ready) begin
            chk("single_outstanding", pend_cnt, 0);
            pend_cnt  = rand_rsp ? int'($urandom_range(1, 3)) : rsp_dly;
            pend_addr = imem_req_addr;
            req_age   = 0;
        end else if (imem_req_valid) begin
            req_age++;
        end else begin
            req_age = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_deliver(input int budget, input string tag);
        int start = deliv_total;
        int n = 0;
        while (deliv_total == start && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_deliver_timeout"}, 32'(deliv_total > start), 1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!imem_req_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_req_timeout", 32'(imem_req_valid), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid_timeout", 32'(inst_valid), 1);
    endtask

    initial begin
        int c0;
        logic [31:0] s_inst;
        logic [31:0] s_pc;

        // Reset
        rst_now = 1'b1;
        tick();
        tick();
        rst_now = 1'b0;
        rst = 1'b0;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);

        // 1: sequential fetch, 3 cycles per instruction
        wait_deliver(10, "t1a");
        chk("t1_pc0", last_deliv_pc, 32'h8000_0000);
        c0 = last_deliv_cyc;
        wait_deliver(10, "t1b");
        chk("t1_pc1", last_deliv_pc, 32'h8000_0004);
        chk("t1_gap1", last_deliv_cyc - c0, 3);
        c0 = last_deliv_cyc;
        wait_deliver(10, "t1c");
        chk("t1_pc2", last_deliv_pc, 32'h8000_0008);
        chk("t1_gap2", last_deliv_cyc - c0, 3);

        // 2: decoder stall holds the word and blocks new requests
        ir_mode = 1;
        wait_valid(10);
        s_inst = inst;
        s_pc   = inst_pc;
        repeat (5) begin
            tick();
            chk("t2_valid_held", 32'(inst_valid), 1);
            chk("t2_inst_stable", inst, s_inst);
            chk("t2_pc_stable", inst_pc, s_pc);
            chk("t2_no_req", 32'(imem_req_valid), 0);
        end
        ir_mode = 0;
        wait_deliver(10, "t2");
        chk("t2_pc", last_deliv_pc, s_pc);

        // 3: redirect in the accepting cycle; stale response must be dropped
        wait_req(10);
        redir_now = 1'b1;
        redir_tgt = 32'h8000_0100;
        tick();
        wait_deliver(10, "t3");
        chk("t3_pc", last_deliv_pc, 32'h8000_0100);

        // 4: unaligned redirect while holding an instruction
        ir_mode = 1;
        wait_valid(10);
        redir_now = 1'b1;
        redir_tgt = 32'h8000_0203;
        tick();
        chk("t4_valid_drop", 32'(inst_valid), 0);
        chk("t4_req_valid", 32'(imem_req_valid), 1);
        chk("t4_req_addr", imem_req_addr, 32'h8000_0200);
        ir_mode = 0;
        wait_deliver(10, "t4");
        chk("t4_pc", last_deliv_pc, 32'h8000_0200);

        // 5: wrap-around, then reset while a fetch is outstanding
        redir_now = 1'b1;
        redir_tgt = 32'hFFFF_FFFC;
        tick();
        wait_deliver(10, "t5a");
        chk("t5_pc_top", last_deliv_pc, 32'hFFFF_FFFC);
        wait_deliver(10, "t5b");
        chk("t5_pc_wrap", last_deliv_pc, 32'h0000_0000);
        wait_deliver(10, "t5c");
        chk("t5_pc_4", last_deliv_pc, 32'h0000_0004);
        rsp_dly = 3;
        wait_req(10);
        tick();
        tick();
        rst_now = 1'b1;
        tick();
        rst_now = 1'b0;
        rsp_dly = 1;
        wait_deliver(10, "t5d");
        chk("t5_refetch", last_deliv_pc, RESET_PC_DEFAULT);

        // 6: slow memory, 4 instructions from reset
        rst_now = 1'b1;
        tick();
        rst_now = 1'b0;
        rdy_mode = 1;
        repeat (4) wait_deliver(20, "t6");
        chk("t6_last_pc", last_deliv_pc, 32'h8000_000C);
`ifdef IFU_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 4);
        chk("t6_perf_stall", perf_stall_cnt, stall_model);
`endif

        // Randomized traffic against the reference model
        rdy_mode   = 2;
        ir_mode    = 2;
        rand_rsp   = 1'b1;
        redir_prob = 6;
        repeat (800) tick();
        redir_prob = 0;
        ir_mode    = 0;
        wait_deliver(50, "rand_end");
`ifdef IFU_PERF_EN
        chk("rand_perf_fetch", perf_fetch_cnt, fetch_model);
        chk("rand_perf_stall", perf_stall_cnt, stall_model);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
